// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle RV32I control unit sequencing FETCH/DECODE/EXEC/MEM/WB with a memory handshake and traps.
// Optional macro UC_PERF_EN adds the InstRet/StallCnt performance counters.
module uc_multiciclo #(
    parameter int OPCODE_W    = 7,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                Branch,
    output logic                JumpPC,
    output logic                JumpRD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                ALUscr,
    output logic                LUIscr,
    output logic                RegWrite,
    output logic                IllegalOp,
    output logic                BusError,
    output logic [2:0]          State
`ifdef UC_PERF_EN
    ,
    output logic [31:0]         InstRet,
    output logic [31:0]         StallCnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               branch;
        logic               jump;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               lui_src;
        logic               reg_write;
        logic               pc_write;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_IALU  = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_JALR  = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BR    = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(7'b0110111);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
    localparam logic [15:0]         TIMEOUT  = 16'(MEM_TIMEOUT);

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   opc_q, opc_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ill_q, ill_d, bus_q, bus_d;
    ctrl_t                 ctrl_q;

    // Zero only steers the PC mux in the datapath; the branch PC write pulse is unconditional.
    logic unused_zero;
    assign unused_zero = Zero;

    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_R, OP_LOAD, OP_IALU, OP_JALR, OP_STORE, OP_BR, OP_LUI, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Moore control word for a state/opcode pair; registered from the next-state values.
    function automatic ctrl_t decode(input state_t s, input logic [OPCODE_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: c.mem_read = 1'b1;
            S_EXEC: begin
                case (op)
                    OP_R:    c.alu_op = ALUOP_W'(1);
                    OP_IALU: begin c.alu_op = ALUOP_W'(2); c.alu_src = 1'b1; end
                    OP_LOAD, OP_STORE: begin c.alu_op = ALUOP_W'(3); c.alu_src = 1'b1; end
                    OP_BR:   begin c.alu_op = ALUOP_W'(4); c.branch = 1'b1; c.pc_write = 1'b1; end
                    OP_LUI:  begin c.alu_op = ALUOP_W'(5); c.alu_src = 1'b1; c.lui_src = 1'b1; end
                    OP_JAL:  c.alu_op = ALUOP_W'(6);
                    OP_JALR: begin c.alu_op = ALUOP_W'(7); c.alu_src = 1'b1; end
                    default: ;
                endcase
            end
            S_MEM: begin
                c.mem_read  = (op == OP_LOAD);
                c.mem_write = (op == OP_STORE);
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.pc_write   = 1'b1;
                c.mem_to_reg = (op == OP_LOAD);
                c.jump       = (op == OP_JAL) || (op == OP_JALR);
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        bus_d   = bus_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) state_d = S_DECODE;
                else if (cnt_q == TIMEOUT) begin state_d = S_TRAP; bus_d = 1'b1; end
                else cnt_d = cnt_q + 16'd1;
            end
            S_DECODE: begin
                opc_d = Opcode;
                if (is_legal(Opcode)) state_d = S_EXEC;
                else begin state_d = S_TRAP; ill_d = 1'b1; end
            end
            S_EXEC: begin
                if (opc_q == OP_BR) state_d = S_FETCH;
                else if (opc_q == OP_LOAD || opc_q == OP_STORE) state_d = S_MEM;
                else state_d = S_WB;
            end
            S_MEM: begin
                if (MemReady) state_d = (opc_q == OP_LOAD) ? S_WB : S_FETCH;
                else if (cnt_q == TIMEOUT) begin state_d = S_TRAP; bus_d = 1'b1; end
                else cnt_d = cnt_q + 16'd1;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            bus_q   <= 1'b0;
            ctrl_q  <= decode(S_FETCH, '0);
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            bus_q   <= bus_d;
            ctrl_q  <= decode(state_d, opc_d);
        end
    end

    // Instruction fetch and store completion happen in the cycle MemReady arrives.
    assign IRWrite   = (state_q == S_FETCH) && MemReady;
    assign PCWrite   = ctrl_q.pc_write || ((state_q == S_MEM) && ctrl_q.mem_write && MemReady);
    assign ALUOp     = ctrl_q.alu_op;
    assign Branch    = ctrl_q.branch;
    assign JumpPC    = ctrl_q.jump;
    assign JumpRD    = ctrl_q.jump;
    assign MemRead   = ctrl_q.mem_read;
    assign MemWrite  = ctrl_q.mem_write;
    assign MemToReg  = ctrl_q.mem_to_reg;
    assign ALUscr    = ctrl_q.alu_src;
    assign LUIscr    = ctrl_q.lui_src;
    assign RegWrite  = ctrl_q.reg_write;
    assign IllegalOp = ill_q;
    assign BusError  = bus_q;
    assign State     = state_q;

`ifdef UC_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstRet  <= '0;
            StallCnt <= '0;
        end else begin
            if (PCWrite) InstRet <= InstRet + 32'd1;
            if ((state_q == S_FETCH || state_q == S_MEM) && !MemReady) StallCnt <= StallCnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
Multicycle RISC-V (RV32I subset) control unit. It replaces the single-cycle combinational decoder with a registered FSM that sequences FETCH/DECODE/EXEC/MEM/WB per instruction. It handshakes with a shared instruction/data memory via MemReady and traps on illegal opcodes or memory timeout. It sits between the datapath (PC, IR, register file, ALU) and the unified memory port.

Parameters:
OPCODE_W, 7, opcode field width
ALUOP_W, 4, ALUOp output width (minimum 3)
MEM_TIMEOUT, 255, max cycles waiting for MemReady before trap (1..2^16-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Opcode  input  OPCODE_W  IR[6:0]; sampled only in DECODE
Zero  input  1  ALU zero flag; sampled in EXEC of branches
MemReady  input  1  memory completes access this cycle
IRWrite  output  1  load IR from memory data
PCWrite  output  1  update PC (one pulse per retired instruction)
ALUOp  output  ALUOP_W  ALU operation class
Branch  output  1  branch instruction in EXEC
JumpPC  output  1  PC target from ALU result (jal/jalr)
JumpRD  output  1  rd gets PC+4
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemToReg  output  1  writeback from memory data
ALUscr  output  1  ALU B operand = immediate
LUIscr  output  1  ALU A operand = zero (lui)
RegWrite  output  1  register file write enable
IllegalOp  output  1  sticky trap flag
BusError  output  1  sticky memory timeout flag
State  output  3  current FSM state (debug)

Behaviour:
- Reset (rst_n=0, async): State=FETCH(0), latched opcode=0, timeout counter=0, IllegalOp=BusError=0. All outputs are Moore functions of state+latched opcode; in FETCH after reset only MemRead=1.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6,7 go to TRAP.
- FETCH: MemRead=1. MemReady=1 -> IRWrite=1 same cycle, next DECODE. Otherwise stay, counter++.
- DECODE: latch Opcode. Legal set: 0110011 R, 0000011 load, 0010011 I-alu, 1100111 jalr, 0100011 S, 1100011 B, 0110111 U, 1101111 J. Illegal -> TRAP, IllegalOp=1. Else -> EXEC.
- EXEC: ALUOp: R=1, I-alu=2, load/S=3, B=4, U=5, J=6, jalr=7; ALUOp=0 in all other states. ALUscr=1 for load, I-alu, jalr, S, U. LUIscr=1 for U. B: Branch=1, PCWrite=1 (datapath chooses target when Zero=1), next FETCH. load/S -> MEM. Others -> WB.
- MEM: load MemRead=1; S MemWrite=1, held until MemReady. On MemReady: load -> WB; S -> PCWrite=1, next FETCH.
- WB: RegWrite=1, PCWrite=1. MemToReg=1 for load. JumpRD=1 and JumpPC=1 for J and jalr. Next FETCH.
- Latency at MemReady=1: B 3 cycles; R/I-alu/U/J/jalr/S 4; load 5.
- Timeout: counter clears on every state entry. Waiting in FETCH/MEM with counter==MEM_TIMEOUT -> TRAP, BusError=1, request deasserted.
- TRAP: all control outputs 0; absorbing until rst_n=0. IllegalOp/BusError are never both set.
- Opcode changes outside DECODE have no effect. MemReady outside FETCH/MEM is ignored.
- Reset mid-MEM aborts the access immediately: MemWrite falls asynchronously.

Optional Feature:
UC_PERF_EN: defined -> adds outputs InstRet[31:0] (increments on each PCWrite) and StallCnt[31:0] (increments per cycle in FETCH/MEM with MemReady=0); both reset to 0 and wrap at 2^32. Undefined -> ports and counters absent; behaviour otherwise identical.

Test Plan:
Reset, MemReady=1, Opcode=0110011 -> states 0,1,2,4,0; ALUOp=1 in EXEC; RegWrite=1 and PCWrite=1 in WB only.
Opcode=0000011, MemReady low 3 cycles in MEM -> MemRead held 4 cycles, then WB with MemToReg=1; total 8 cycles.
Opcode=1100011, Zero=1 -> 3 cycles, Branch=1 and PCWrite=1 in EXEC, no RegWrite.
Opcode=1101111 -> ALUOp=6 in EXEC; WB has JumpPC=JumpRD=RegWrite=1.
Opcode=1111111 -> TRAP at cycle 2, IllegalOp=1 sticky; rst_n pulse clears to FETCH.
MEM_TIMEOUT=4, MemReady=0 in FETCH -> TRAP after 5 cycles, BusError=1, MemRead=0; with UC_PERF_EN StallCnt=5, InstRet=0.
